// File: rtl/wb_regfile_scoreboard_if.sv
// Writeback/issue/read-port bundle between the pipeline control and the register file.
// The master side drives writeback, issue and read addresses; the slave side is the register file.
interface wb_regfile_scoreboard_if #(
    parameter int unsigned XLEN = 32
);
    logic            wb_valid;
    logic            wb_wen;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            iss_valid;
    logic            iss_wen;
    logic [4:0]      iss_rd;
    logic            iss_ready;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            flush;
    logic            err_underflow;

    modport master (
        output wb_valid, wb_wen, wb_rd, wb_data,
        output iss_valid, iss_wen, iss_rd,
        output rs1_addr, rs2_addr, flush,
        input  iss_ready, rs1_data, rs2_data, rs1_busy, rs2_busy, err_underflow
    );

    modport slave (
        input  wb_valid, wb_wen, wb_rd, wb_data,
        input  iss_valid, iss_wen, iss_rd,
        input  rs1_addr, rs2_addr, flush,
        output iss_ready, rs1_data, rs2_data, rs1_busy, rs2_busy, err_underflow
    );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// 32x32 register file with write-to-read bypass and a per-register pending-writer
// scoreboard that marks destinations busy from issue until writeback.
module wb_regfile_scoreboard #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned XLEN  = 32
) (
    input logic                    clock,
    input logic                    reset,
    wb_regfile_scoreboard_if.slave bus
);
    logic [XLEN-1:0]  regs    [32];
    logic [CNT_W-1:0] cnt_q   [32];
    logic [CNT_W-1:0] cnt_d   [32];
    logic [31:0]      inc_vec;
    logic [31:0]      dec_vec;
    logic             err_q;
    logic             err_d;
    logic             commit;
    logic             iss_ready;
    logic             iss_fire;

    assign commit   = bus.wb_valid && bus.wb_wen && (bus.wb_rd != 5'd0);
    assign iss_fire = bus.iss_valid && iss_ready;

    // A commit to the same register frees a slot, so a saturated counter can still accept.
    assign iss_ready = !(bus.iss_wen && (bus.iss_rd != 5'd0) && (cnt_q[bus.iss_rd] == '1)
                         && !(commit && (bus.wb_rd == bus.iss_rd)));

    always_comb begin
        bus.rs1_data = regs[bus.rs1_addr];
        if (commit && (bus.wb_rd == bus.rs1_addr)) bus.rs1_data = bus.wb_data;
        if (bus.rs1_addr == 5'd0) bus.rs1_data = '0;
        bus.rs2_data = regs[bus.rs2_addr];
        if (commit && (bus.wb_rd == bus.rs2_addr)) bus.rs2_data = bus.wb_data;
        if (bus.rs2_addr == 5'd0) bus.rs2_data = '0;
    end

    // The last pending writer retiring this cycle is covered by the bypass, so not busy.
    always_comb begin
        bus.rs1_busy = (cnt_q[bus.rs1_addr] != '0) &&
                       !((cnt_q[bus.rs1_addr] == CNT_W'(1)) && commit &&
                         (bus.wb_rd == bus.rs1_addr));
        bus.rs2_busy = (cnt_q[bus.rs2_addr] != '0) &&
                       !((cnt_q[bus.rs2_addr] == CNT_W'(1)) && commit &&
                         (bus.wb_rd == bus.rs2_addr));
    end

    assign bus.iss_ready     = iss_ready;
    assign bus.err_underflow = err_q;

    always_comb begin
        err_d = err_q;
        for (int r = 0; r < 32; r++) begin
            inc_vec[r] = iss_fire && bus.iss_wen && (bus.iss_rd == 5'(r)) && (r != 0);
            dec_vec[r] = commit && (bus.wb_rd == 5'(r));
            cnt_d[r]   = cnt_q[r];
            if (bus.flush) begin
                cnt_d[r] = '0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                regs[r]  <= '0;
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (commit) regs[bus.wb_rd] <= bus.wb_data;
            for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: reset, bypass, saturation, x0, flush, mid-run reset.
module tb_wb_regfile_scoreboard;
    logic clock;
    logic reset;
    int   passed;
    int   total;

    wb_regfile_scoreboard_if #(.XLEN(32)) bus ();

    wb_regfile_scoreboard #(
        .CNT_W (2),
        .XLEN  (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change on the falling edge; checks run 1 time unit later, well before the rising edge.
    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic idle();
        bus.wb_valid  = 1'b0;
        bus.wb_wen    = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 32'h0;
        bus.iss_valid = 1'b0;
        bus.iss_wen   = 1'b0;
        bus.iss_rd    = 5'd0;
        bus.flush     = 1'b0;
    endtask

    task automatic commit_to(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_wen   = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = data;
    endtask

    task automatic issue_to(input logic [4:0] rd);
        bus.iss_valid = 1'b1;
        bus.iss_wen   = 1'b1;
        bus.iss_rd    = rd;
    endtask

    task automatic test_reset();
        idle();
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd0;
        bus.iss_wen  = 1'b1;
        bus.iss_rd   = 5'd5;
        #1;
        total++; if (bus.rs1_data !== 32'h0) $display("FAIL reset_rs1_data got %h want 0", bus.rs1_data); else passed++;
        total++; if (bus.rs2_data !== 32'h0) $display("FAIL reset_rs2_data got %h want 0", bus.rs2_data); else passed++;
        total++; if (bus.rs1_busy !== 1'b0) $display("FAIL reset_rs1_busy got %b want 0", bus.rs1_busy); else passed++;
        total++; if (bus.rs2_busy !== 1'b0) $display("FAIL reset_rs2_busy got %b want 0", bus.rs2_busy); else passed++;
        total++; if (bus.iss_ready !== 1'b1) $display("FAIL reset_iss_ready got %b want 1", bus.iss_ready); else passed++;
        total++; if (bus.err_underflow !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err_underflow); else passed++;
        next_cycle();
        idle();
    endtask

    task automatic test_issue_commit();
        bus.rs1_addr = 5'd5;
        issue_to(5'd5);
        #1;
        total++; if (bus.rs1_busy !== 1'b0) $display("FAIL ic_issue_cycle_busy got %b want 0", bus.rs1_busy); else passed++;
        next_cycle();
        idle();
        #1;
        total++; if (bus.rs1_busy !== 1'b1) $display("FAIL ic_pending_busy got %b want 1", bus.rs1_busy); else passed++;
        next_cycle();
        commit_to(5'd5, 32'hDEADBEEF);
        #1;
        total++; if (bus.rs1_busy !== 1'b0) $display("FAIL ic_commit_busy got %b want 0", bus.rs1_busy); else passed++;
        total++; if (bus.rs1_data !== 32'hDEADBEEF) $display("FAIL ic_bypass got %h want deadbeef", bus.rs1_data); else passed++;
        next_cycle();
        idle();
        #1;
        total++; if (bus.rs1_data !== 32'hDEADBEEF) $display("FAIL ic_stored got %h want deadbeef", bus.rs1_data); else passed++;
        total++; if (bus.rs1_busy !== 1'b0) $display("FAIL ic_after_busy got %b want 0", bus.rs1_busy); else passed++;
        next_cycle();
    endtask

    task automatic test_saturate();
        bus.rs1_addr = 5'd7;
        for (int i = 0; i < 3; i++) begin
            issue_to(5'd7);
            #1;
            total++; if (bus.iss_ready !== 1'b1) $display("FAIL sat_fill%0d got %b want 1", i, bus.iss_ready); else passed++;
            next_cycle();
        end
        issue_to(5'd7);
        #1;
        total++; if (bus.iss_ready !== 1'b0) $display("FAIL sat_full got %b want 0", bus.iss_ready); else passed++;
        next_cycle();
        commit_to(5'd7, 32'h0000_0070);
        #1;
        total++; if (bus.iss_ready !== 1'b1) $display("FAIL sat_commit_ready got %b want 1", bus.iss_ready); else passed++;
        total++; if (bus.rs1_busy !== 1'b1) $display("FAIL sat_commit_busy got %b want 1", bus.rs1_busy); else passed++;
        next_cycle();
        idle();
        issue_to(5'd7);
        #1;
        total++; if (bus.iss_ready !== 1'b0) $display("FAIL sat_still3 got %b want 0", bus.iss_ready); else passed++;
        next_cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            commit_to(5'd7, 32'h0000_0071 + i);
            next_cycle();
        end
        idle();
        #1;
        total++; if (bus.rs1_busy !== 1'b0) $display("FAIL sat_drained_busy got %b want 0", bus.rs1_busy); else passed++;
        total++; if (bus.rs1_data !== 32'h0000_0073) $display("FAIL sat_drained_data got %h want 73", bus.rs1_data); else passed++;
        total++; if (bus.err_underflow !== 1'b0) $display("FAIL sat_err got %b want 0", bus.err_underflow); else passed++;
        next_cycle();
    endtask

    task automatic test_x0();
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        commit_to(5'd0, 32'h0000_1234);
        #1;
        total++; if (bus.rs1_data !== 32'h0) $display("FAIL x0_bypass got %h want 0", bus.rs1_data); else passed++;
        next_cycle();
        idle();
        issue_to(5'd0);
        #1;
        total++; if (bus.rs1_data !== 32'h0) $display("FAIL x0_read got %h want 0", bus.rs1_data); else passed++;
        total++; if (bus.err_underflow !== 1'b0) $display("FAIL x0_err got %b want 0", bus.err_underflow); else passed++;
        total++; if (bus.iss_ready !== 1'b1) $display("FAIL x0_ready got %b want 1", bus.iss_ready); else passed++;
        next_cycle();
        idle();
        #1;
        total++; if (bus.rs2_busy !== 1'b0) $display("FAIL x0_busy got %b want 0", bus.rs2_busy); else passed++;
        next_cycle();
    endtask

    task automatic test_flush();
        bus.rs1_addr = 5'd3;
        issue_to(5'd3);
        next_cycle();
        issue_to(5'd3);
        next_cycle();
        idle();
        commit_to(5'd3, 32'h0000_0055);
        issue_to(5'd3);
        bus.flush = 1'b1;
        #1;
        total++; if (bus.rs1_data !== 32'h0000_0055) $display("FAIL fl_bypass got %h want 55", bus.rs1_data); else passed++;
        next_cycle();
        idle();
        #1;
        total++; if (bus.rs1_busy !== 1'b0) $display("FAIL fl_cleared_busy got %b want 0", bus.rs1_busy); else passed++;
        total++; if (bus.rs1_data !== 32'h0000_0055) $display("FAIL fl_data got %h want 55", bus.rs1_data); else passed++;
        total++; if (bus.err_underflow !== 1'b0) $display("FAIL fl_no_err got %b want 0", bus.err_underflow); else passed++;
        commit_to(5'd3, 32'h0000_0066);
        next_cycle();
        idle();
        #1;
        total++; if (bus.err_underflow !== 1'b1) $display("FAIL fl_underflow got %b want 1", bus.err_underflow); else passed++;
        next_cycle();
        #1;
        total++; if (bus.err_underflow !== 1'b1) $display("FAIL fl_sticky got %b want 1", bus.err_underflow); else passed++;
        total++; if (bus.rs1_data !== 32'h0000_0066) $display("FAIL fl_late_data got %h want 66", bus.rs1_data); else passed++;
    endtask

    task automatic test_reset_mid();
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd5;
        issue_to(5'd9);
        next_cycle();
        issue_to(5'd9);
        commit_to(5'd9, 32'hA5A5A5A5);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        idle();
        #1;
        total++; if (bus.rs1_data !== 32'h0) $display("FAIL rm_reg9 got %h want 0", bus.rs1_data); else passed++;
        total++; if (bus.rs1_busy !== 1'b0) $display("FAIL rm_busy9 got %b want 0", bus.rs1_busy); else passed++;
        total++; if (bus.rs2_data !== 32'h0) $display("FAIL rm_reg5 got %h want 0", bus.rs2_data); else passed++;
        total++; if (bus.err_underflow !== 1'b0) $display("FAIL rm_err got %b want 0", bus.err_underflow); else passed++;
        commit_to(5'd9, 32'h0000_0001);
        next_cycle();
        idle();
        #1;
        total++; if (bus.err_underflow !== 1'b1) $display("FAIL rm_cnt9_zero got %b want 1", bus.err_underflow); else passed++;
        next_cycle();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        idle();
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        test_reset();
        test_issue_commit();
        test_saturate();
        test_x0();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
